// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI master
//
// Purpose : opcode conventions, FSM state encoding and SPI mode constants used by
//           spi_sck_gen and spi_master_param.
// Contents: OP_WRITE / OP_READ, SPI_MODE0..3 ({CPOL,CPHA}), spi_state_t, max_int().

package spi_pkg;

  localparam logic [7:0] OP_WRITE = 8'h80;
  localparam logic [7:0] OP_READ  = 8'h00;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK divider, half-period tick and edge strobes
//
// Purpose : counts CLK_DIV clk cycles per SCK half-period while run is high and
//           toggles the SCK register on each tick when toggle_en is high.
// Ports   : clk, reset_n (async, active-low)
//           run       in  divider enable; counter and sck forced idle when low
//           toggle_en in  allow sck to toggle on tick
//           tick      out one-clk pulse at the end of each half-period
//           sck       out registered SCK
//           lead      out tick that moves sck away from CPOL
//           trail     out tick that returns sck to CPOL

module spi_sck_gen #(
  parameter int CLK_DIV = 4,
  parameter bit CPOL    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic toggle_en,
  output logic tick,
  output logic sck,
  output logic lead,
  output logic trail
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick  = run && (cnt == CW'(CLK_DIV - 1));
  assign lead  = tick && toggle_en && (sck == CPOL);
  assign trail = tick && toggle_en && (sck != CPOL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck <= CPOL;
    end else if (!run) begin
      sck <= CPOL;
    end else if (tick && toggle_en) begin
      sck <= ~sck;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// rtl/spi_master_param.sv - parametrised synchronous SPI master, one command per transaction
//
// Purpose : opcode byte followed by cmd_len data words (write or read), MSB first,
//           configurable width, divider, CPOL/CPHA and chip selects.
// Ports   : clk, reset_n (async, active-low)
//           cmd_valid/cmd_ready, cmd_rw, cmd_opcode[7:0], cmd_len[LEN_W], cmd_cs[CS_W]
//           tx_data[DATA_W]/tx_valid/tx_ready   write words
//           rx_data[DATA_W]/rx_valid/rx_ready   read words (one held word max)
//           busy, sck, mosi, miso, ss_n[NUM_CS]
//           loopback (only with SPI_MASTER_LOOPBACK_EN): sample mosi internally, ss_n quiet
// Macro   : SPI_MASTER_LOOPBACK_EN

module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CS  = 1,
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 8,
  parameter bit CPOL    = 1'b0,
  parameter bit CPHA    = 1'b0,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [7:0]        cmd_opcode,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [CS_W-1:0]   cmd_cs,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] ss_n
`ifdef SPI_MASTER_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  // Transmit shifter is wide enough for both the 8-bit opcode and a data word,
  // left-aligned so mosi always comes from the top bit.
  localparam int MAXW = max_int(8, DATA_W);
  localparam int BCW  = $clog2(MAXW);

  spi_state_t        state, state_nx;
  logic              rw_q;
  logic              op_phase;
  logic              hold_phase;
  logic [LEN_W-1:0]  words_left;
  logic [BCW-1:0]    bit_cnt;
  logic [MAXW-1:0]   tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] ss_q;
  logic [NUM_CS-1:0] cs_dec;

  logic              tick, lead, trail, sck_i;
  logic              run, toggle_en;
  logic              lb_active;
  logic              sample_in;
  logic              sample_ev, drive_ev;
  logic              last_bit, last_word, word_done;
  logic              post_word, rx_room;
  logic              cmd_hs, load_go;
  logic [MAXW-1:0]   op_vec, load_vec;
  logic [DATA_W-1:0] load_word;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign lb_active = loopback;
`else
  assign lb_active = 1'b0;
`endif

  assign run       = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign toggle_en = (state == ST_SHIFT);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sck_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .toggle_en (toggle_en),
    .tick      (tick),
    .sck       (sck_i),
    .lead      (lead),
    .trail     (trail)
  );

  // Loopback samples the bit currently on mosi, which is already valid at the sampling edge.
  assign sample_in = lb_active ? mosi_q : miso;

  assign last_bit  = op_phase ? (bit_cnt == BCW'(7)) : (bit_cnt == BCW'(DATA_W - 1));
  assign last_word = op_phase ? (words_left == '0) : (words_left == LEN_W'(1));
  assign word_done = (state == ST_SHIFT) && trail && last_bit;

  // CPHA=0: sample on leading edge, next bit on trailing edge (first bit pre-driven at load).
  // CPHA=1: drive on leading edge, sample on trailing edge.
  assign sample_ev = (state == ST_SHIFT) && (CPHA ? trail : lead);
  assign drive_ev  = (state == ST_SHIFT) && (CPHA ? lead : (trail && !last_bit));

  // With CPHA=1 the final sample lands on the same edge that completes the word.
  assign rx_word = CPHA ? {rx_sh[DATA_W-2:0], sample_in} : rx_sh;

  // Words that complete into the rx holding register: reads, plus loopback writes.
  assign post_word = !rw_q || lb_active;
  assign rx_room   = !rx_valid_q || rx_ready;

  assign cmd_hs    = (state == ST_IDLE) && cmd_valid;
  assign op_vec    = MAXW'(cmd_opcode) << (MAXW - 8);
  assign load_word = rw_q ? tx_data : '0;
  assign load_vec  = MAXW'(load_word) << (MAXW - DATA_W);

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cmd_cs == CS_W'(i)) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    tx_ready  = 1'b0;
    load_go   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_nx = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (word_done) begin
          state_nx = last_word ? ST_HOLD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // SCK is parked here, so a full rx holding register stalls only between words.
        tx_ready = rw_q && (!post_word || rx_room);
        load_go  = (!post_word || rx_room) && (!rw_q || tx_valid);
        if (load_go) begin
          state_nx = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (tick && hold_phase) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q       <= 1'b0;
      op_phase   <= 1'b0;
      hold_phase <= 1'b0;
      words_left <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      mosi_q     <= 1'b0;
      ss_q       <= '1;
    end else begin
      if (cmd_hs) begin
        rw_q       <= cmd_rw;
        words_left <= cmd_len;
        op_phase   <= 1'b1;
        hold_phase <= 1'b0;
        bit_cnt    <= '0;
        ss_q       <= cs_dec;
        if (!CPHA) begin
          mosi_q <= op_vec[MAXW-1];
          tx_sh  <= op_vec << 1;
        end else begin
          tx_sh  <= op_vec;
        end
      end

      if (drive_ev) begin
        mosi_q <= tx_sh[MAXW-1];
        tx_sh  <= tx_sh << 1;
      end

      if (sample_ev) begin
        rx_sh <= {rx_sh[DATA_W-2:0], sample_in};
      end

      if ((state == ST_SHIFT) && trail) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);
      end

      if (word_done) begin
        op_phase <= 1'b0;
        if (!op_phase && (words_left != '0)) begin
          words_left <= words_left - LEN_W'(1);
        end
      end

      if (load_go) begin
        if (!CPHA) begin
          mosi_q <= load_vec[MAXW-1];
          tx_sh  <= load_vec << 1;
        end else begin
          tx_sh  <= load_vec;
        end
      end

      // First HOLD tick releases ss_n; the second guarantees a half-period of
      // deselect before cmd_ready can rise again.
      if ((state == ST_HOLD) && tick) begin
        ss_q       <= '1;
        hold_phase <= !hold_phase;
        if (hold_phase) begin
          mosi_q <= 1'b0;
        end
      end

      // Opcode-phase capture is never posted.
      if (word_done && !op_phase && post_word) begin
        rx_data_q  <= rx_word;
        rx_valid_q <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign sck      = sck_i;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign ss_n     = lb_active ? '1 : ss_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb/tb_spi_master_param.sv - directed self-checking bench for spi_master_param
//
// Purpose : dut_a is mode 0 / one select, dut_b is mode 3 / four selects, both CLK_DIV=2.
//           SPI-side monitors log mosi at every rising SCK and check ss_n there; a slave
//           model for dut_a shifts a preloaded vector onto miso at each falling SCK.

`timescale 1ns/1ps

module tb_spi_master_param;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // dut_a: mode 0, NUM_CS=1
  logic       cmd_valid_a, cmd_ready_a, cmd_rw_a;
  logic [7:0] cmd_opcode_a, cmd_len_a;
  logic [0:0] cmd_cs_a;
  logic [7:0] tx_data_a, rx_data_a;
  logic       tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a;
  logic       busy_a, sck_a, mosi_a, miso_a;
  logic [0:0] ss_n_a;

  // dut_b: mode 3, NUM_CS=4
  logic       cmd_valid_b, cmd_ready_b, cmd_rw_b;
  logic [7:0] cmd_opcode_b, cmd_len_b;
  logic [1:0] cmd_cs_b;
  logic [7:0] tx_data_b, rx_data_b;
  logic       tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b;
  logic       busy_b, sck_b, mosi_b, miso_b;
  logic [3:0] ss_n_b;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic loopback_a = 1'b0;
  logic loopback_b = 1'b0;
`endif

  spi_master_param #(
    .DATA_W(8), .NUM_CS(1), .CLK_DIV(2), .LEN_W(8), .CPOL(1'b0), .CPHA(1'b0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_rw(cmd_rw_a),
    .cmd_opcode(cmd_opcode_a), .cmd_len(cmd_len_a), .cmd_cs(cmd_cs_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .busy(busy_a), .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .ss_n(ss_n_a)
`ifdef SPI_MASTER_LOOPBACK_EN
    , .loopback(loopback_a)
`endif
  );

  spi_master_param #(
    .DATA_W(8), .NUM_CS(4), .CLK_DIV(2), .LEN_W(8), .CPOL(1'b1), .CPHA(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_rw(cmd_rw_b),
    .cmd_opcode(cmd_opcode_b), .cmd_len(cmd_len_b), .cmd_cs(cmd_cs_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .busy(busy_b), .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .ss_n(ss_n_b)
`ifdef SPI_MASTER_LOOPBACK_EN
    , .loopback(loopback_b)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  // SPI-side monitors (only ever increment / shift; the bench uses snapshots)
  int          rise_a = 0, fall_a = 0, ss_bad_a = 0;
  logic [63:0] mlog_a = '0;
  logic [0:0]  exp_ss_a = 1'b1;
  int          rise_b = 0, ss_bad_b = 0;
  logic [63:0] mlog_b = '0;
  logic [3:0]  exp_ss_b = 4'hF;

  always @(posedge sck_a) if (reset_n) begin
    rise_a++;
    mlog_a = {mlog_a[62:0], mosi_a};
    if (ss_n_a !== exp_ss_a) ss_bad_a++;
  end
  always @(negedge sck_a) if (reset_n) fall_a++;

  always @(posedge sck_b) if (reset_n) begin
    rise_b++;
    mlog_b = {mlog_b[62:0], mosi_b};
    if (ss_n_b !== exp_ss_b) ss_bad_b++;
  end

  // Mode-0 slave: bit 63 is on miso before the first edge, one bit further per falling SCK.
  logic [63:0] slave_vec_a = '0;
  int          fall_base_a = 0;
  always @* begin
    int idx;
    idx = 63 - (fall_a - fall_base_a);
    if (idx < 0) idx = 0;
    if (idx > 63) idx = 63;
    miso_a = slave_vec_a[idx];
  end

  logic [7:0] tx_words [0:3];
  int         tx_idx;
  logic [7:0] rx_got [0:7];
  int         rx_n;
  int         base, base_ss, cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic start_a(input logic rw, input logic [7:0] op, input logic [7:0] len,
                         input logic cs);
    @(negedge clk);
    fall_base_a  = fall_a;
    cmd_rw_a     = rw;
    cmd_opcode_a = op;
    cmd_len_a    = len;
    cmd_cs_a     = cs;
    cmd_valid_a  = 1'b1;
    @(negedge clk);
    cmd_valid_a  = 1'b0;
  endtask

  // Runs dut_a to completion, feeding tx_words and recording accepted rx words.
  task automatic run_a(input string tag, input int max_cyc);
    int  c;
    bit  pend;
    c = 0;
    pend = 1'b0;
    while ((busy_a || rx_valid_a) && c < max_cyc) begin
      if (pend) begin
        tx_idx++;
        tx_data_a = tx_words[tx_idx % 4];
        pend = 1'b0;
      end
      if (tx_valid_a && tx_ready_a) pend = 1'b1;
      if (rx_valid_a && rx_ready_a) begin
        rx_got[rx_n % 8] = rx_data_a;
        rx_n++;
      end
      @(negedge clk);
      c++;
    end
    check({tag, "_done_in_time"}, c < max_cyc, 1'b1);
  endtask

  task automatic start_b(input logic rw, input logic [7:0] op, input logic [7:0] len,
                         input logic [1:0] cs);
    @(negedge clk);
    cmd_rw_b     = rw;
    cmd_opcode_b = op;
    cmd_len_b    = len;
    cmd_cs_b     = cs;
    cmd_valid_b  = 1'b1;
    @(negedge clk);
    cmd_valid_b  = 1'b0;
  endtask

  task automatic run_b(input string tag, input int max_cyc);
    int c;
    c = 0;
    while (busy_b && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_in_time"}, c < max_cyc, 1'b1);
  endtask

  initial begin
    cmd_valid_a = 0; cmd_rw_a = 0; cmd_opcode_a = 0; cmd_len_a = 0; cmd_cs_a = 0;
    tx_data_a = 0; tx_valid_a = 0; rx_ready_a = 1;
    cmd_valid_b = 0; cmd_rw_b = 0; cmd_opcode_b = 0; cmd_len_b = 0; cmd_cs_b = 0;
    tx_data_b = 0; tx_valid_b = 0; rx_ready_b = 1; miso_b = 0;
    tx_idx = 0; rx_n = 0;
    for (int i = 0; i < 4; i++) tx_words[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_sck_a",       sck_a, 1'b0);
    check("rst_mosi_a",      mosi_a, 1'b0);
    check("rst_ss_n_a",      ss_n_a, 1'b1);
    check("rst_cmd_ready_a", cmd_ready_a, 1'b1);
    check("rst_tx_ready_a",  tx_ready_a, 1'b0);
    check("rst_rx_valid_a",  rx_valid_a, 1'b0);
    check("rst_rx_data_a",   rx_data_a, 8'h00);
    check("rst_busy_a",      busy_a, 1'b0);
    check("rst_sck_b",       sck_b, 1'b1);
    check("rst_ss_n_b",      ss_n_b, 4'hF);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0 write 0x80, A5, 3C
    tx_words[0] = 8'hA5; tx_words[1] = 8'h3C; tx_idx = 0;
    tx_data_a = tx_words[0]; tx_valid_a = 1'b1;
    exp_ss_a = 1'b0; base = rise_a; base_ss = ss_bad_a;
    start_a(1'b1, 8'h80, 8'd2, 1'b0);
    check("wr_busy_a", busy_a, 1'b1);
    run_a("wr", 400);
    tx_valid_a = 1'b0;
    check("wr_rises",    rise_a - base, 24);
    check("wr_mosi",     mlog_a[23:0], 24'h80A53C);
    check("wr_ss_low",   ss_bad_a - base_ss, 0);
    check("wr_tx_taken", tx_idx, 2);
    check("wr_ss_after", ss_n_a, 1'b1);

    // Mode 0 read, slave returns 0x5A
    slave_vec_a = {8'h00, 8'h5A, 48'h0};
    rx_n = 0; base = rise_a; base_ss = ss_bad_a;
    start_a(1'b0, 8'h00, 8'd1, 1'b0);
    run_a("rd1", 400);
    check("rd1_count",   rx_n, 1);
    check("rd1_word",    rx_got[0], 8'h5A);
    check("rd1_rx_data", rx_data_a, 8'h5A);
    check("rd1_rises",   rise_a - base, 16);
    check("rd1_mosi0",   mlog_a[15:0], 16'h0000);
    check("rd1_ss_low",  ss_bad_a - base_ss, 0);

    // Read len=3 with the consumer stalled after word 1
    slave_vec_a = {8'h00, 8'h11, 8'h22, 8'h33, 32'h0};
    rx_n = 0; rx_ready_a = 1'b0; base = rise_a;
    start_a(1'b0, 8'h00, 8'd3, 1'b0);
    cyc = 0;
    while (!rx_valid_a && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_word1_in_time", cyc < 400, 1'b1);
    repeat (40) @(negedge clk);
    check("bp_rx_data1", rx_data_a, 8'h11);
    check("bp_rises",    rise_a - base, 16);
    check("bp_sck_idle", sck_a, 1'b0);
    check("bp_busy",     busy_a, 1'b1);
    rx_ready_a = 1'b1;
    run_a("bp", 600);
    check("bp_count",       rx_n, 3);
    check("bp_w1",          rx_got[0], 8'h11);
    check("bp_w2",          rx_got[1], 8'h22);
    check("bp_w3",          rx_got[2], 8'h33);
    check("bp_total_rises", rise_a - base, 32);

    // len=0 with an out-of-range select: opcode only, no ss_n asserted
    exp_ss_a = 1'b1; base = rise_a; base_ss = ss_bad_a; rx_n = 0;
    start_a(1'b0, 8'hA7, 8'd0, 1'b1);
    check("len0_ss_mid", ss_n_a, 1'b1);
    run_a("len0", 200);
    check("len0_rises", rise_a - base, 8);
    check("len0_mosi",  mlog_a[7:0], 8'hA7);
    check("len0_ss",    ss_bad_a - base_ss, 0);
    check("len0_no_rx", rx_n, 0);

    // Mode 3, cs=2, write 0xC3
    tx_data_b = 8'hC3; tx_valid_b = 1'b1;
    exp_ss_b = 4'b1011; base = rise_b; base_ss = ss_bad_b;
    start_b(1'b1, 8'h80, 8'd1, 2'd2);
    repeat (4) @(negedge clk);
    check("m3_ss_mid", ss_n_b, 4'b1011);
    run_b("m3", 400);
    check("m3_rises",  rise_b - base, 16);
    check("m3_mosi",   mlog_b[15:0], 16'h80C3);
    check("m3_ss",     ss_bad_b - base_ss, 0);
    check("m3_sck_idle", sck_b, 1'b1);

    // Reset in the middle of word 2
    base = rise_b;
    start_b(1'b1, 8'h80, 8'd2, 2'd2);
    cyc = 0;
    while ((rise_b - base) < 20 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached", cyc < 1000, 1'b1);
    check("rst_mid_busy_before", busy_b, 1'b1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_sck",  sck_b, 1'b1);
    check("rst_mid_ss",   ss_n_b, 4'hF);
    check("rst_mid_busy", busy_b, 1'b0);
    check("rst_mid_rdy",  cmd_ready_b, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Clean transaction after the reset
    tx_data_b = 8'h5E;
    exp_ss_b = 4'b1101; base = rise_b; base_ss = ss_bad_b;
    start_b(1'b1, 8'h80, 8'd1, 2'd1);
    run_b("post_rst", 400);
    tx_valid_b = 1'b0;
    check("post_rst_rises", rise_b - base, 16);
    check("post_rst_mosi",  mlog_b[15:0], 16'h805E);
    check("post_rst_ss",    ss_bad_b - base_ss, 0);

`ifdef SPI_MASTER_LOOPBACK_EN
    loopback_a = 1'b1;
    tx_words[0] = 8'h96; tx_words[1] = 8'h00; tx_idx = 0;
    tx_data_a = tx_words[0]; tx_valid_a = 1'b1;
    exp_ss_a = 1'b1; base = rise_a; base_ss = ss_bad_a; rx_n = 0;
    start_a(1'b1, 8'h80, 8'd1, 1'b0);
    check("lb_ss_mid", ss_n_a, 1'b1);
    run_a("lb", 400);
    tx_valid_a = 1'b0;
    check("lb_count", rx_n, 1);
    check("lb_word",  rx_got[0], 8'h96);
    check("lb_rises", rise_a - base, 16);
    check("lb_ss",    ss_bad_a - base_ss, 0);
    loopback_a = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
